// File: rtl/axil_cmd_master_if.sv
`default_nettype none
// ============================================================================
// Module      : axil_cmd_master_if
// Description : AXI-lite bus bundle (AW, W, B, AR, R channels) used between
//               axil_cmd_master and the slave side of the interconnect.
//               Modport 'master' is the initiating end, 'slave' the target.
// Parameters  : ADDR_WIDTH - AWADDR/ARADDR width
//               DATA_WIDTH - WDATA/RDATA width (32)
// Revision    : 1.0 - initial release
// ============================================================================
interface axil_cmd_master_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   logic                    AWVALID;
   logic                    AWREADY;
   logic [ADDR_WIDTH-1:0]   AWADDR;
   logic [2:0]              AWPROT;
   logic                    WVALID;
   logic                    WREADY;
   logic [DATA_WIDTH-1:0]   WDATA;
   logic [DATA_WIDTH/8-1:0] WSTRB;
   logic                    BVALID;
   logic                    BREADY;
   logic [1:0]              BRESP;
   logic                    ARVALID;
   logic                    ARREADY;
   logic [ADDR_WIDTH-1:0]   ARADDR;
   logic [2:0]              ARPROT;
   logic                    RVALID;
   logic                    RREADY;
   logic [DATA_WIDTH-1:0]   RDATA;
   logic [1:0]              RRESP;

   modport master (
      output AWVALID, AWADDR, AWPROT, input AWREADY,
      output WVALID, WDATA, WSTRB, input WREADY,
      input BVALID, BRESP, output BREADY,
      output ARVALID, ARADDR, ARPROT, input ARREADY,
      input RVALID, RDATA, RRESP, output RREADY
   );

   modport slave (
      input AWVALID, AWADDR, AWPROT, output AWREADY,
      input WVALID, WDATA, WSTRB, output WREADY,
      output BVALID, BRESP, input BREADY,
      input ARVALID, ARADDR, ARPROT, output ARREADY,
      output RVALID, RDATA, RRESP, input RREADY
   );
endinterface
`default_nettype wire

// File: rtl/axil_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : axil_cmd_master
// Description : Single-outstanding AXI-lite master. Converts one command-port
//               request into one AXI-lite read or write and returns the
//               response on the response port. No pipelining.
// Ports       : S_AXI_ACLK, i_reset (sync, active-high)
//               cmd : i_cmd_valid/o_cmd_ready, i_cmd_we, i_cmd_addr,
//                     i_cmd_data, i_cmd_strb
//               rsp : o_rsp_valid/i_rsp_ready, o_rsp_data, o_rsp_resp,
//                     o_rsp_timeout
//               M_AXI : AXI-lite master modport (axil_cmd_master_if)
// Options     : `define AXIL_CMD_MASTER_TIMEOUT_EN to enable the response
//               timeout (TIMEOUT cycles) with DRAIN of late responses.
// Revision    : 1.0 - initial release
// ============================================================================
module axil_cmd_master #(
   parameter int C_AXI_ADDR_WIDTH = 8,
   parameter int C_AXI_DATA_WIDTH = 32,
   parameter int TIMEOUT          = 255
) (
   input  wire logic                        S_AXI_ACLK,
   input  wire logic                        i_reset,
   input  wire logic                        i_cmd_valid,
   output logic                             o_cmd_ready,
   input  wire logic                        i_cmd_we,
   input  wire logic [C_AXI_ADDR_WIDTH-1:0] i_cmd_addr,
   input  wire logic [C_AXI_DATA_WIDTH-1:0] i_cmd_data,
   input  wire logic [3:0]                  i_cmd_strb,
   output logic                             o_rsp_valid,
   input  wire logic                        i_rsp_ready,
   output logic [C_AXI_DATA_WIDTH-1:0]      o_rsp_data,
   output logic [1:0]                       o_rsp_resp,
   output logic                             o_rsp_timeout,
   axil_cmd_master_if.master                M_AXI
);
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_READ  = 3'd2,
      S_RESP  = 3'd3
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
      , S_DRAIN = 3'd4
`endif
   } state_t;

   state_t                      r_state, w_state_next;
   logic                        r_awvalid, r_wvalid, r_arvalid;
   logic                        r_we;
   logic                        r_pend;     // B/R still owed by the slave
   logic [C_AXI_ADDR_WIDTH-1:0] r_addr;
   logic [C_AXI_DATA_WIDTH-1:0] r_wdata;
   logic [3:0]                  r_wstrb;
   logic [C_AXI_DATA_WIDTH-1:0] r_rsp_data;
   logic [1:0]                  r_rsp_resp;
   logic                        r_rsp_timeout;

   logic w_accept, w_bready, w_rready, w_b_hs, w_r_hs, w_resp_hs;
   logic w_timeout, w_to_resp;

   assign w_accept  = (r_state == S_IDLE) && i_cmd_valid;
   assign w_bready  = r_pend && r_we;
   assign w_rready  = r_pend && !r_we && !r_arvalid;
   // B only counts once both AW and W have been handed over.
   assign w_b_hs    = M_AXI.BVALID && w_bready && !r_awvalid && !r_wvalid;
   assign w_r_hs    = M_AXI.RVALID && w_rready;
   assign w_resp_hs = w_b_hs || w_r_hs;

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] r_cnt;

   // Saturating cycle counter restarted by every command accept.
   always_ff @(posedge S_AXI_ACLK) begin
      if (i_reset)
         r_cnt <= '0;
      else if (w_accept)
         r_cnt <= '0;
      else if (r_cnt != CW'(TIMEOUT))
         r_cnt <= r_cnt + 1'b1;
   end

   assign w_timeout = (r_cnt == CW'(TIMEOUT));
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge S_AXI_ACLK) begin
      if (i_reset)
         r_state <= S_IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:
            if (w_accept)
               w_state_next = i_cmd_we ? S_WRITE : S_READ;
         S_WRITE, S_READ:
            if (w_resp_hs || w_timeout)
               w_state_next = S_RESP;
         S_RESP:
            if (i_rsp_ready) begin
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
               // After a timeout the real response is still owed; swallow it.
               w_state_next = (r_pend && !w_resp_hs) ? S_DRAIN : S_IDLE;
`else
               w_state_next = S_IDLE;
`endif
            end
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
         S_DRAIN:
            if (w_resp_hs)
               w_state_next = S_IDLE;
`endif
         default:
            w_state_next = S_IDLE;
      endcase
   end

   assign w_to_resp = ((r_state == S_WRITE) || (r_state == S_READ)) &&
                      (w_state_next == S_RESP);

   always_ff @(posedge S_AXI_ACLK) begin
      if (i_reset) begin
         r_awvalid     <= 1'b0;
         r_wvalid      <= 1'b0;
         r_arvalid     <= 1'b0;
         r_we          <= 1'b0;
         r_pend        <= 1'b0;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_wstrb       <= '0;
         r_rsp_data    <= '0;
         r_rsp_resp    <= 2'b00;
         r_rsp_timeout <= 1'b0;
      end else begin
         if (w_accept) begin
            r_addr    <= i_cmd_addr;
            r_wdata   <= i_cmd_data;
            r_wstrb   <= i_cmd_strb;
            r_we      <= i_cmd_we;
            r_awvalid <= i_cmd_we;
            r_wvalid  <= i_cmd_we;
            r_arvalid <= !i_cmd_we;
            r_pend    <= 1'b1;
         end else begin
            if (r_awvalid && M_AXI.AWREADY) r_awvalid <= 1'b0;
            if (r_wvalid  && M_AXI.WREADY)  r_wvalid  <= 1'b0;
            if (r_arvalid && M_AXI.ARREADY) r_arvalid <= 1'b0;
            if (w_resp_hs)                  r_pend    <= 1'b0;
         end
         if (w_to_resp) begin
            r_rsp_resp    <= w_b_hs ? M_AXI.BRESP :
                             w_r_hs ? M_AXI.RRESP : 2'b10;
            r_rsp_data    <= w_r_hs ? M_AXI.RDATA : '0;
            r_rsp_timeout <= w_timeout && !w_resp_hs;
         end
      end
   end

   assign o_cmd_ready   = (r_state == S_IDLE);
   assign o_rsp_valid   = (r_state == S_RESP);
   assign o_rsp_data    = r_rsp_data;
   assign o_rsp_resp    = r_rsp_resp;
   assign o_rsp_timeout = r_rsp_timeout;

   assign M_AXI.AWVALID = r_awvalid;
   assign M_AXI.AWADDR  = r_addr;
   assign M_AXI.AWPROT  = 3'b000;
   assign M_AXI.WVALID  = r_wvalid;
   assign M_AXI.WDATA   = r_wdata;
   assign M_AXI.WSTRB   = r_wstrb;
   assign M_AXI.BREADY  = w_bready;
   assign M_AXI.ARVALID = r_arvalid;
   assign M_AXI.ARADDR  = r_addr;
   assign M_AXI.ARPROT  = 3'b000;
   assign M_AXI.RREADY  = w_rready;
endmodule
`default_nettype wire

// File: tb/tb_axil_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_cmd_master
// Description : Directed self-checking bench for axil_cmd_master. The bench
//               plays the AXI-lite slave by driving the interface directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_cmd_master;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid, cmd_ready, cmd_we;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_data;
   logic [3:0]    cmd_strb;
   logic          rsp_valid, rsp_ready, rsp_timeout;
   logic [DW-1:0] rsp_data;
   logic [1:0]    rsp_resp;

   int n_cmp = 0;
   int n_err = 0;

   axil_cmd_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   axil_cmd_master #(
      .C_AXI_ADDR_WIDTH(AW), .C_AXI_DATA_WIDTH(DW), .TIMEOUT(TO)
   ) dut (
      .S_AXI_ACLK   (clk),
      .i_reset      (rst),
      .i_cmd_valid  (cmd_valid),
      .o_cmd_ready  (cmd_ready),
      .i_cmd_we     (cmd_we),
      .i_cmd_addr   (cmd_addr),
      .i_cmd_data   (cmd_data),
      .i_cmd_strb   (cmd_strb),
      .o_rsp_valid  (rsp_valid),
      .i_rsp_ready  (rsp_ready),
      .o_rsp_data   (rsp_data),
      .o_rsp_resp   (rsp_resp),
      .o_rsp_timeout(rsp_timeout),
      .M_AXI        (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cmd(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      cmd_valid = 1'b1;
      cmd_we    = we;
      cmd_addr  = a;
      cmd_data  = d;
      cmd_strb  = 4'hF;
   endtask

   initial begin
      rst = 1'b1;
      cmd_valid = 0; cmd_we = 0; cmd_addr = '0; cmd_data = '0; cmd_strb = '0;
      rsp_ready = 0;
      bus.AWREADY = 0; bus.WREADY = 0; bus.BVALID = 0; bus.BRESP = 2'b00;
      bus.ARREADY = 0; bus.RVALID = 0; bus.RDATA = '0; bus.RRESP = 2'b00;
      tick(); tick();
      rst = 1'b0;

      // ---- reset state
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_valids", {bus.AWVALID, bus.WVALID, bus.ARVALID}, 3'b000);
      chk("rst_readies", {bus.BREADY, bus.RREADY}, 2'b00);
      chk("rst_rsp", {rsp_valid, rsp_timeout}, 2'b00);
      chk("rst_addr", bus.AWADDR, 0);
      chk("rst_prot", {bus.AWPROT, bus.ARPROT}, 6'b0);

      // ---- zero-wait write
      cmd(1'b1, 8'h10, 32'hDEADBEEF);
      bus.AWREADY = 1; bus.WREADY = 1;
      tick();
      cmd_valid = 0;
      chk("w1_valids", {bus.AWVALID, bus.WVALID}, 2'b11);
      chk("w1_payload", {bus.AWADDR, bus.WDATA, bus.WSTRB}, {8'h10, 32'hDEADBEEF, 4'hF});
      chk("w1_ready", {cmd_ready, bus.BREADY}, 2'b01);
      bus.BVALID = 1; bus.BRESP = 2'b00;
      tick();
      bus.AWREADY = 0; bus.WREADY = 0;
      chk("w1_valids_drop", {bus.AWVALID, bus.WVALID}, 2'b00);
      tick();
      bus.BVALID = 0;
      chk("w1_rsp", {rsp_valid, rsp_resp, rsp_timeout}, {1'b1, 2'b00, 1'b0});
      chk("w1_rsp_data", rsp_data, 0);
      chk("w1_bready_off", bus.BREADY, 0);
      rsp_ready = 1;
      tick();
      rsp_ready = 0;
      chk("w1_idle", {cmd_ready, rsp_valid}, 2'b10);

      // ---- write, W three cycles before AW
      cmd(1'b1, 8'h44, 32'h0BADF00D);
      tick();
      cmd_valid = 0;
      bus.WREADY = 1;
      tick();
      bus.WREADY = 0;
      chk("w2_w_first", {bus.AWVALID, bus.WVALID}, 2'b10);
      tick();
      chk("w2_aw_held", {bus.AWVALID, bus.AWADDR}, {1'b1, 8'h44});
      tick();
      // B raised together with AWREADY: must not count until AW is done
      bus.AWREADY = 1; bus.BVALID = 1; bus.BRESP = 2'b00;
      chk("w2_aw_held2", {bus.AWVALID, bus.AWADDR}, {1'b1, 8'h44});
      tick();
      bus.AWREADY = 0;
      chk("w2_aw_done", {bus.AWVALID, rsp_valid}, 2'b00);
      tick();
      bus.BVALID = 0;
      chk("w2_rsp", {rsp_valid, rsp_resp}, {1'b1, 2'b00});
      rsp_ready = 1;
      tick();
      rsp_ready = 0;
      chk("w2_idle", {cmd_ready, rsp_valid}, 2'b10);

      // ---- read with delayed R, then stalled response consumer
      cmd(1'b0, 8'h24, 32'h0);
      bus.ARREADY = 1;
      tick();
      cmd_valid = 0;
      chk("r1_arvalid", {bus.ARVALID, bus.ARADDR, bus.AWVALID, bus.RREADY}, {1'b1, 8'h24, 2'b00});
      tick();
      bus.ARREADY = 0;
      chk("r1_ar_done", {bus.ARVALID, bus.RREADY}, 2'b01);
      for (int i = 0; i < 4; i++) tick();
      chk("r1_waiting", rsp_valid, 0);
      bus.RVALID = 1; bus.RDATA = 32'h12345678; bus.RRESP = 2'b00;
      tick();
      bus.RVALID = 0; bus.RDATA = '0;
      chk("r1_rsp", {rsp_valid, rsp_resp, rsp_data}, {1'b1, 2'b00, 32'h12345678});
      cmd(1'b1, 8'h99, 32'h55555555);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("hold_rsp", {rsp_valid, rsp_resp, rsp_data, cmd_ready}, {1'b1, 2'b00, 32'h12345678, 1'b0});
         chk("hold_no_req", {bus.AWVALID, bus.WVALID, bus.ARVALID}, 3'b000);
      end
      cmd_valid = 0;
      rsp_ready = 1;
      tick();
      rsp_ready = 0;
      chk("hold_release", {rsp_valid, cmd_ready}, 2'b01);
      tick();
      chk("busy_cmd_dropped", {bus.AWVALID, bus.WVALID, cmd_ready}, 3'b001);

      // ---- error-only slave, write
      cmd(1'b1, 8'h80, 32'h1);
      bus.AWREADY = 1; bus.WREADY = 1;
      tick();
      cmd_valid = 0;
      tick();
      bus.AWREADY = 0; bus.WREADY = 0;
      bus.BVALID = 1; bus.BRESP = 2'b11;
      tick();
      bus.BVALID = 0; bus.BRESP = 2'b00;
      chk("e_w_rsp", {rsp_valid, rsp_resp, rsp_data}, {1'b1, 2'b11, 32'h0});
      tick();
      chk("e_w_busy", cmd_ready, 0);
      rsp_ready = 1;
      tick();
      rsp_ready = 0;
      chk("e_w_idle", cmd_ready, 1);

      // ---- error-only slave, read
      cmd(1'b0, 8'h84, 32'h0);
      bus.ARREADY = 1;
      tick();
      cmd_valid = 0;
      tick();
      bus.ARREADY = 0;
      bus.RVALID = 1; bus.RRESP = 2'b11; bus.RDATA = '0;
      tick();
      bus.RVALID = 0; bus.RRESP = 2'b00;
      chk("e_r_rsp", {rsp_valid, rsp_resp, cmd_ready}, {1'b1, 2'b11, 1'b0});
      rsp_ready = 1;
      tick();
      rsp_ready = 0;
      chk("e_r_idle", cmd_ready, 1);

      // ---- reset in the middle of a write
      cmd(1'b1, 8'h30, 32'hCAFEF00D);
      tick();
      cmd_valid = 0;
      chk("mid_w_valid", {bus.AWVALID, bus.WVALID}, 2'b11);
      rst = 1;
      tick();
      chk("mid_rst_valids", {bus.AWVALID, bus.WVALID, bus.ARVALID, bus.BREADY}, 4'b0000);
      chk("mid_rst_ready", {cmd_ready, rsp_valid}, 2'b10);
      rst = 0;
      tick();

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
      // ---- read against a silent slave; late R discarded
      cmd(1'b0, 8'h50, 32'h0);
      bus.ARREADY = 1;
      tick();                          // accept edge (cycle 0)
      cmd_valid = 0;
      tick();                          // cycle 1: AR handshake
      bus.ARREADY = 0;
      for (int i = 2; i <= 8; i++) tick();
      chk("to_not_yet", rsp_valid, 0);
      tick();                          // cycle 9
      chk("to_rsp", {rsp_valid, rsp_timeout, rsp_resp, rsp_data}, {1'b1, 1'b1, 2'b10, 32'h0});
      rsp_ready = 1;
      tick();                          // cycle 10
      rsp_ready = 0;
      chk("to_drain", {rsp_valid, cmd_ready}, 2'b00);
      for (int i = 11; i <= 20; i++) tick();
      chk("to_drain_wait", cmd_ready, 0);
      bus.RVALID = 1; bus.RDATA = 32'hFFFFFFFF; bus.RRESP = 2'b00;
      tick();                          // cycle 21
      bus.RVALID = 0; bus.RDATA = '0;
      chk("to_drained", {cmd_ready, rsp_valid}, 2'b10);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/axil_cmd_master.md
Name: axil_cmd_master

Overview:
- Single-outstanding AXI-lite master: turns one command-port request into one AXI-lite read or write, then returns the response.
- Acts as the initiating end of the bus. Used by test harnesses, debug bridges and configuration sequencers to drive AXI-lite slaves through the interconnect, including the error-only empty slave.
- Exactly one transaction in flight; no pipelining.

Parameters:
- C_AXI_ADDR_WIDTH, 8, address width of command and AW/AR channels
- C_AXI_DATA_WIDTH, 32, data width; fixed at 32
- TIMEOUT, 255, cycles to wait for B/R before timeout fires (used only with the optional feature); minimum 4

Ports:
- S_AXI_ACLK  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_cmd_valid  in  1  command request
- o_cmd_ready  out  1  command accepted when valid&&ready
- i_cmd_we  in  1  1=write, 0=read
- i_cmd_addr  in  C_AXI_ADDR_WIDTH  target address
- i_cmd_data  in  32  write data
- i_cmd_strb  in  4  write strobes
- o_rsp_valid  out  1  response available
- i_rsp_ready  in  1  response consumed
- o_rsp_data  out  32  read data; 0 for writes
- o_rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout
- o_rsp_timeout  out  1  response was generated by timeout
- M_AXI_AWVALID/AWREADY/AWADDR/AWPROT  out/in/out/out  1/1/AW/3
- M_AXI_WVALID/WREADY/WDATA/WSTRB  out/in/out/out  1/1/32/4
- M_AXI_BVALID/BREADY/BRESP  in/out/in  1/1/2
- M_AXI_ARVALID/ARREADY/ARADDR/ARPROT  out/in/out/out  1/1/AW/3
- M_AXI_RVALID/RREADY/RDATA/RRESP  in/out/in/in  1/1/32/2

Behaviour:
- Reset is synchronous on S_AXI_ACLK. All VALID outputs, o_rsp_valid and o_rsp_timeout are 0; BREADY and RREADY are 0; o_cmd_ready is 1; data/address registers are 0. AWPROT/ARPROT are constant 3'b000.
- Reset mid-transaction drops all VALIDs the next cycle and discards any response.
- States:
  - IDLE: o_cmd_ready=1. On accept, address/data/strb are registered. we=1 -> WRITE with AWVALID=WVALID=1; we=0 -> READ with ARVALID=1. Request valids rise the cycle after acceptance.
  - WRITE: AWVALID and WVALID clear independently on their own handshakes, so AW and W may complete in any order or the same cycle. BREADY=1 throughout WRITE. A B handshake is accepted only after both AW and W have completed.
  - READ: ARVALID clears on ARREADY. RREADY=1 once AR has completed.
  - RESP: entered on the B or R handshake. Captures BRESP, or RRESP+RDATA. o_rsp_valid=1 and held stable until i_rsp_ready, then returns to IDLE. o_cmd_ready=0 throughout.
- Latency: command accept to request VALID = 1 cycle. Response handshake to o_rsp_valid = 1 cycle. Minimum command-to-command period = 4 cycles for a zero-wait slave.
- AXI rules: VALIDs and their payloads are never withdrawn or altered before the handshake. VALID never depends combinationally on READY.
- o_rsp_data is 0 for writes and for timeouts.
- i_cmd_valid while busy is ignored; it is not latched.

Optional Feature:
- Macro AXIL_CMD_MASTER_TIMEOUT_EN.
- Defined:
  - A counter runs from the command accept. If B/R has not arrived after TIMEOUT cycles, go to RESP with o_rsp_resp=2'b10, o_rsp_timeout=1.
  - Pending request VALIDs are held (never dropped) until their handshakes complete.
  - The late response is absorbed and discarded in state DRAIN. o_cmd_ready stays 0 until both the response consumer and the drain complete.
  - The counter saturates and is cleared on every accept.
- Undefined: no counter, no DRAIN state; o_rsp_timeout tied 0; waits forever.

Test Plan:
- Write 0x10<=0xDEADBEEF strb 4'hF, slave with AWREADY/WREADY=1, BRESP=00 -> AW/W valid 1 cycle after accept; o_rsp_valid with resp=00, data=0.
- Write where WREADY arrives 3 cycles before AWREADY -> WVALID drops first, AWVALID held with addr stable; single B accepted; resp=00.
- Read 0x24, slave returns RDATA=0x12345678, RRESP=00 after 5-cycle delay -> o_rsp_data=0x12345678, resp=00; ARVALID dropped after ARREADY.
- Read and write against the error-only slave -> resp=2'b11 on both; o_cmd_ready returns to 1 only after i_rsp_ready.
- i_rsp_ready held low 10 cycles -> o_rsp_* stable; second i_cmd_valid not accepted; reset mid-WRITE -> all VALIDs 0 next cycle, o_cmd_ready=1.
- (AXIL_CMD_MASTER_TIMEOUT_EN, TIMEOUT=8) slave never answers a read -> o_rsp_timeout=1, resp=2'b10 at cycle 9 after accept; a late R at cycle 20 is discarded and o_cmd_ready rises 1 cycle later.
